// File: rtl/note_shift_bank_if.sv
// Control, data and status bundle for the note shift bank.
// master drives the controls and observes status; slave is the bank.
interface note_shift_bank_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             EN;
    logic [1:0]       mode;
    logic [WIDTH-1:0] D;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_sel;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             evict;

    modport master (
        output EN, mode, D, sel,
        input  Q, Q_sel, count, full, evict
    );

    modport slave (
        input  EN, mode, D, sel,
        output Q, Q_sel, count, full, evict
    );
endinterface

// File: rtl/note_shift_bank.sv
// DEPTH-stage shift bank of recent note codes: hold/shift-in/rotate/clear, occupancy and eviction flag.
// Latency: one edge for stage 0, DEPTH edges to Q; Q, full and Q_sel decode straight from registers.
// No backpressure: EN gates every update, and shifting while full discards the oldest entry.
module note_shift_bank #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset_button,
    note_shift_bank_if.slave   bus
);
    localparam int SEL_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CNT_W-1:0] count_r;
    logic             evict_r;

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            count_r <= '0;
            evict_r <= 1'b0;
        end else begin
            // evict is a pulse: anything but a shift into a full bank drops it
            evict_r <= 1'b0;
            if (bus.EN) begin
                case (bus.mode)
                    MODE_SHIFT: begin
                        stage[0] <= bus.D;
                        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                        if (count_r != CNT_FULL) count_r <= count_r + CNT_W'(1);
                        evict_r <= (count_r == CNT_FULL);
                    end
                    MODE_ROTATE: begin
                        stage[0] <= stage[DEPTH-1];
                        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                    end
                    MODE_CLEAR: begin
                        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                        count_r <= '0;
                    end
                    MODE_HOLD: ;
                    default: ;
                endcase
            end
        end
    end

    // Compare-based mux so out-of-range sel on non-power-of-two DEPTH reads 0
    always_comb begin
        bus.Q_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.sel == SEL_W'(i)) bus.Q_sel = stage[i];
        end
    end

    assign bus.Q     = stage[DEPTH-1];
    assign bus.count = count_r;
    assign bus.full  = (count_r == CNT_FULL);
    assign bus.evict = evict_r;
endmodule
